// File: rtl/hms_mode_ctrl.sv
// hms_mode_ctrl: synchronous mode/setup sequencer for the HH:MM:SS clock datapath.
// Debounces the three push buttons, generates the 1 Hz tick, schedules sec->min->hour
// carries as single-cycle increment strobes and drives setup position, auto-repeat and
// the digit-blink mask.
//
// Ports:
//   clk, rst_n                    system clock, asynchronous active-low reset
//   i_sw0 / i_sw1 / i_sw2         mode / position / increment buttons, active-low
//   i_sec_max, i_min_max          counters at 59 (carry qualifiers)
//   i_hour_max                    unused, the hour counter wraps by itself
//   o_sec_inc/o_min_inc/o_hour_inc one-cycle registered increment strobes
//   o_mode                        0 = CLOCK, 1 = SETUP
//   o_position                    0 = SEC, 1 = MIN, 2 = HOUR
//   o_blink_mask                  1 = blank digit; [1:0] sec, [3:2] min, [5:4] hour
module hms_mode_ctrl #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned DEB_DIV     = 500000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned REPEAT_DLY  = 100,
  parameter int unsigned REPEAT_RATE = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sec_max,
  input  logic       i_min_max,
  input  logic       i_hour_max,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic [5:0] o_blink_mask
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DebW   = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned HoldW  = $clog2(REPEAT_DLY + 1);

  localparam logic [TickW-1:0]  TickLast   = TickW'(TICK_DIV - 1);
  localparam logic [DebW-1:0]   DebLast    = DebW'(DEB_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast  = BlinkW'(BLINK_DIV - 1);
  localparam logic [HoldW-1:0]  HoldRepeat = HoldW'(REPEAT_DLY);
  // After a repeat the counter restarts REPEAT_RATE samples short of the threshold.
  localparam logic [HoldW-1:0]  HoldReload = HoldW'(REPEAT_DLY - REPEAT_RATE);

  localparam logic       ModeClock = 1'b0;
  localparam logic       ModeSetup = 1'b1;
  localparam logic [1:0] PosSec    = 2'd0;
  localparam logic [1:0] PosMin    = 2'd1;
  localparam logic [1:0] PosHour   = 2'd2;

  logic unused_hour_max;
  assign unused_hour_max = i_hour_max;

  // Button sampler state; bit order {sw2, sw1, sw0}.
  logic [DebW-1:0] deb_cnt_q;
  logic            smp_q;
  logic [2:0]      cur_q, prev_q, armed_q;
  logic            sample_en;
  logic [2:0]      btn_raw;
  logic [2:0]      press;

  // Timekeeping and setup state.
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [HoldW-1:0]  hold_inc;
  logic              mode_q, mode_d;
  logic [1:0]        pos_q, pos_d;
  logic              sec_inc_q, min_inc_q, hour_inc_q;
  logic              sec_inc_d, min_inc_d, hour_inc_d;

  logic tick, rep_fire, setup_inc, enter_setup, pos_adv;

  assign btn_raw   = {i_sw2, i_sw1, i_sw0};
  assign sample_en = (deb_cnt_q == DebLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      smp_q     <= 1'b0;
      cur_q     <= 3'b111;
      prev_q    <= 3'b111;
      armed_q   <= 3'b000;
    end else begin
      smp_q     <= sample_en;
      deb_cnt_q <= sample_en ? '0 : deb_cnt_q + DebW'(1);
      if (sample_en) begin
        cur_q   <= btn_raw;
        prev_q  <= cur_q;
        // A button held through reset must be seen released before it can fire.
        armed_q <= armed_q | btn_raw;
      end
    end
  end

  // Press events are valid the cycle after the sample that captured them.
  assign press = {3{smp_q}} & prev_q & ~cur_q & armed_q;

  assign hold_inc = hold_q + HoldW'(1);
  assign rep_fire = smp_q & ~cur_q[2] & ~prev_q[2] & armed_q[2] & (hold_inc == HoldRepeat);

  assign tick        = (mode_q == ModeClock) && (tick_cnt_q == TickLast);
  assign enter_setup = press[0] && (mode_q == ModeClock);
  // sw0 wins over sw1/sw2; sw1 wins over sw2.
  assign pos_adv     = press[1] && !press[0] && (mode_q == ModeSetup);
  assign setup_inc   = (mode_q == ModeSetup) && (press[2] || rep_fire) && !press[0] && !press[1];

  always_comb begin
    tick_cnt_d = tick_cnt_q + TickW'(1);
    if (mode_q == ModeSetup || tick) begin
      tick_cnt_d = '0;
    end

    hold_d = hold_q;
    if (enter_setup) begin
      hold_d = '0;
    end else if (smp_q) begin
      if (cur_q[2] || !armed_q[2] || prev_q[2]) begin
        hold_d = '0;
      end else if (hold_inc == HoldRepeat) begin
        hold_d = HoldReload;
      end else begin
        hold_d = hold_inc;
      end
    end

    mode_d = mode_q;
    if (press[0]) begin
      mode_d = (mode_q == ModeClock) ? ModeSetup : ModeClock;
    end

    pos_d = pos_q;
    if (enter_setup) begin
      pos_d = PosSec;
    end else if (pos_adv) begin
      pos_d = (pos_q == PosHour) ? PosSec : pos_q + 2'd1;
    end

    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    phase_d     = phase_q;
    if (mode_q == ModeClock || pos_adv) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    // Decisions use the mode/position registered before this cycle's update.
    sec_inc_d  = tick || (setup_inc && pos_q == PosSec);
    min_inc_d  = (tick && i_sec_max) || (setup_inc && pos_q == PosMin);
    hour_inc_d = (tick && i_sec_max && i_min_max) || (setup_inc && pos_q == PosHour);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      hold_q      <= '0;
      mode_q      <= ModeClock;
      pos_q       <= PosSec;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      hour_inc_q  <= hour_inc_d;
    end
  end

  always_comb begin
    o_blink_mask = 6'b000000;
    if (mode_q == ModeSetup && phase_q) begin
      unique case (pos_q)
        PosSec:  o_blink_mask = 6'b000011;
        PosMin:  o_blink_mask = 6'b001100;
        PosHour: o_blink_mask = 6'b110000;
        default: o_blink_mask = 6'b000000;
      endcase
    end
  end

  assign o_sec_inc  = sec_inc_q;
  assign o_min_inc  = min_inc_q;
  assign o_hour_inc = hour_inc_q;
  assign o_mode     = mode_q;
  assign o_position = pos_q;

endmodule

// File: doc/hms_mode_ctrl.md
Name: hms_mode_ctrl

Overview:
Synchronous mode/setup sequencer for the HH:MM:SS clock datapath. It replaces the gated-clock scheme with single-cycle increment strobes on the system clock. It debounces the three push buttons, generates the 1 Hz timekeeping tick and schedules carries between the sec/min/hour counters. It also drives setup-mode position selection, button auto-repeat and a digit-blink mask for the display multiplexer.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick
DEB_DIV, 500000, clk cycles per button sample (100 Hz)
BLINK_DIV, 25000000, clk cycles per blink half-period
REPEAT_DLY, 100, button samples that i_sw2 must be held before auto-repeat starts
REPEAT_RATE, 20, button samples between auto-repeat increments

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
i_sw0  input  1  mode button, active-low (pressed = 0)
i_sw1  input  1  position button, active-low
i_sw2  input  1  increment button, active-low
i_sec_max  input  1  sec counter currently at 59
i_min_max  input  1  min counter currently at 59
i_hour_max  input  1  hour counter currently at 23
o_sec_inc  output  1  one-cycle increment strobe, sec counter
o_min_inc  output  1  one-cycle increment strobe, min counter
o_hour_inc  output  1  one-cycle increment strobe, hour counter
o_mode  output  1  0 = CLOCK, 1 = SETUP
o_position  output  2  0 = SEC, 1 = MIN, 2 = HOUR (3 never produced)
o_blink_mask  output  6  1 = blank digit; [1:0] sec, [3:2] min, [5:4] hour

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - All strobes 0, o_mode = CLOCK, o_position = SEC, o_blink_mask = 0.
  - All dividers 0, blink phase 0.
  - Button sample registers set to 1 (released), so no press event follows reset release.
- Button sampler:
  - Sample enable fires when the DEB_DIV counter reaches DEB_DIV-1; the counter then wraps to 0.
  - Each button has a 2-stage sample register (cur, prev) updated only on sample enable.
  - A press event is a one-clk pulse the cycle after the sample where prev = 1 and cur = 0.
  - A released button (cur = 1) clears that button's hold counter.
- 1 Hz tick:
  - The tick counter runs only in CLOCK mode; tick pulses at count TICK_DIV-1, then the counter wraps to 0.
  - The tick counter is held at 0 while in SETUP, so the first tick after returning to CLOCK occurs exactly TICK_DIV cycles later.
- Strobes in CLOCK mode, on the tick cycle:
  - o_sec_inc = 1.
  - o_min_inc = i_sec_max.
  - o_hour_inc = i_sec_max & i_min_max.
  - i_hour_max is ignored; the hour counter self-wraps.
- Strobes in SETUP mode:
  - An i_sw2 event pulses only the strobe of the selected position. There is no carry.
  - Auto-repeat: while i_sw2 stays sampled low, the hold counter counts samples. On reaching REPEAT_DLY it issues an increment, then issues one every REPEAT_RATE samples.
- Strobes are registered and are high for exactly one clk.
- Mode FSM (CLOCK <-> SETUP):
  - An i_sw0 event toggles the mode.
  - Entering SETUP forces o_position = SEC, blink phase = 0, hold counter = 0.
- Position:
  - An i_sw1 event in SETUP advances SEC -> MIN -> HOUR -> SEC.
  - i_sw1 is ignored in CLOCK.
  - A position change resets the blink phase to 0 and the blink counter to 0.
- Blink:
  - In SETUP the phase toggles every BLINK_DIV cycles.
  - When phase = 1, the two mask bits of the selected position are 1; all other bits are 0.
  - In CLOCK the mask is all 0 and the blink counter is held at 0.
- Simultaneous events:
  - Strobe decisions use the mode and position values registered before this cycle's update.
  - A tick in the same cycle as a CLOCK -> SETUP switch still emits its strobes.
  - i_sw0 has priority: an i_sw1 or i_sw2 event in the same cycle as an i_sw0 event is discarded.
  - i_sw1 and i_sw2 in the same cycle: position advances, no increment.
- Reset mid-operation (strobe high, setup in progress, button held): everything returns to the reset values immediately. A held button produces no event until it is released and pressed again.

Test Plan:
Use TICK_DIV = 10, DEB_DIV = 2, BLINK_DIV = 8, REPEAT_DLY = 4, REPEAT_RATE = 2.
1. Reset release with all buttons released -> o_sec_inc pulses exactly every 10 clk, first pulse 10 clk after release; o_min_inc and o_hour_inc stay 0; mask = 0.
2. i_sec_max = 1 and i_min_max = 1 at a tick -> o_sec_inc, o_min_inc and o_hour_inc all high in the same single cycle; with only i_sec_max = 1 -> o_hour_inc stays 0.
3. Press i_sw0 -> o_mode = 1, o_position = 0, ticks stop. Press i_sw2 once -> a single o_sec_inc pulse. Press i_sw1 twice -> o_position = 2, and the next i_sw2 press gives only o_hour_inc.
4. SETUP with position MIN, i_sw2 held low for 12 samples -> o_min_inc pulses at sample counts 0 (press), 4, 6, 8, 10; released -> no further pulses.
5. SETUP with position HOUR, run 32 clk -> o_blink_mask alternates 6'b000000 / 6'b110000 every 8 clk. An i_sw1 press wraps o_position to 0 and the mask restarts at 0.
6. i_sw0 and i_sw2 pressed in the same sample, and separately rst_n pulsed low while i_sw2 is held -> mode toggles with no increment; after reset, no event until i_sw2 is released and re-pressed.
